div_top: RTL and testbench

DIV_TOP -- requirements
Module: div_top

---
 rtl/div_pkg.sv | 40 ++++
 rtl/div_divider.sv | 65 ++++++
 rtl/div_top.sv | 144 ++++++++++++++
 tb/tb_div_top.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared M-extension ISA definitions and datapath width for the divide unit.
// XLEN falls back to 32 when arvi_defines has not already provided it.
`ifndef XLEN
`define XLEN 32
`endif

package div_pkg;

  localparam int XLEN = `XLEN;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Codes outside 1xx fall through to unsigned quotient (DIVU behaviour).
  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return {XLEN{1'b0}} - v;
  endfunction

endpackage

// File: rtl/div_divider.sv
// Unsigned restoring divider: one shift-subtract step per cycle over 32 cycles.
// o_done is high during the final step; results are valid from the next cycle.
module divider
  import div_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvs_r;
  logic [4:0]      cnt_r;
  logic            run_r;

  logic [XLEN:0]   partial_s;
  logic [XLEN-1:0] diff_s;
  logic            ge_s;

  // Trial subtraction on the 33-bit partial remainder; when it fits, the low 32 bits are exact.
  always_comb begin
    partial_s = {rem_r, quo_r[XLEN-1]};
    ge_s      = (partial_s >= {1'b0, dvs_r});
    diff_s    = partial_s[XLEN-1:0] - dvs_r;
  end

  // Iteration state: load on start, then shift one quotient bit in per cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rem_r <= {XLEN{1'b0}};
      quo_r <= {XLEN{1'b0}};
      dvs_r <= {XLEN{1'b0}};
      cnt_r <= 5'd0;
      run_r <= 1'b0;
    end else if (i_start) begin
      rem_r <= {XLEN{1'b0}};
      quo_r <= i_dividend;
      dvs_r <= i_divisor;
      cnt_r <= 5'd31;
      run_r <= 1'b1;
    end else if (run_r) begin
      rem_r <= ge_s ? diff_s : partial_s[XLEN-1:0];
      quo_r <= {quo_r[XLEN-2:0], ge_s};
      cnt_r <= cnt_r - 5'd1;
      run_r <= (cnt_r != 5'd0);
    end else begin
      rem_r <= rem_r;
      quo_r <= quo_r;
      dvs_r <= dvs_r;
      cnt_r <= cnt_r;
      run_r <= run_r;
    end
  end

  assign o_done      = run_r && (cnt_r == 5'd0);
  assign o_quotient  = quo_r;
  assign o_remainder = rem_r;

endmodule

// File: rtl/div_top.sv
// RV32M divide/remainder unit: sign handling, special cases, control FSM and
// result register around the unsigned iterative divider.
module div_top
  import div_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_res
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  div_state_e      state_r;
  div_state_e      state_nxt_s;
  logic [2:0]      f3_r;
  logic            rs1_neg_r;
  logic            rs2_neg_r;
  logic            busy_r;
  logic            done_r;
  logic [XLEN-1:0] res_r;

  logic            sgn_s;
  logic            dz_s;
  logic            ovf_s;
  logic            accept_s;
  logic            div_start_s;
  logic [XLEN-1:0] mag1_s;
  logic [XLEN-1:0] mag2_s;
  logic [XLEN-1:0] special_res_s;
  logic [XLEN-1:0] sign_res_s;
  logic            div_done_s;
  logic [XLEN-1:0] quo_s;
  logic [XLEN-1:0] rem_s;

  // Operand decode: magnitudes for the core and the two bypass cases.
  always_comb begin
    sgn_s  = is_signed_op(i_f3);
    dz_s   = (i_rs2 == {XLEN{1'b0}});
    ovf_s  = sgn_s && (i_rs1 == MIN_NEG) && (i_rs2 == ALL_ONE);
    mag1_s = (sgn_s && i_rs1[XLEN-1]) ? negate(i_rs1) : i_rs1;
    mag2_s = (sgn_s && i_rs2[XLEN-1]) ? negate(i_rs2) : i_rs2;
    if (dz_s) begin
      special_res_s = is_rem_op(i_f3) ? i_rs1 : ALL_ONE;
    end else begin
      special_res_s = is_rem_op(i_f3) ? {XLEN{1'b0}} : MIN_NEG;
    end
  end

  // Sign fix-up applied to the core result using the captured operation.
  always_comb begin
    if (is_rem_op(f3_r)) begin
      sign_res_s = (is_signed_op(f3_r) && rs1_neg_r) ? negate(rem_s) : rem_s;
    end else begin
      sign_res_s = (is_signed_op(f3_r) && (rs1_neg_r ^ rs2_neg_r)) ? negate(quo_s) : quo_s;
    end
  end

  // Next-state logic; starts are only honoured in IDLE or DONE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    div_start_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          accept_s = 1'b1;
          if (dz_s || ovf_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CALC;
            div_start_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (div_done_s) begin
          state_nxt_s = ST_SIGN;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_SIGN: state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, capture and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      f3_r      <= 3'b000;
      rs1_neg_r <= 1'b0;
      rs2_neg_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      res_r     <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_CALC) || (state_nxt_s == ST_SIGN);
      done_r  <= (state_nxt_s == ST_DONE);
      if (accept_s) begin
        f3_r      <= i_f3;
        rs1_neg_r <= i_rs1[XLEN-1];
        rs2_neg_r <= i_rs2[XLEN-1];
      end else begin
        f3_r      <= f3_r;
        rs1_neg_r <= rs1_neg_r;
        rs2_neg_r <= rs2_neg_r;
      end
      if (accept_s && (dz_s || ovf_s)) begin
        res_r <= special_res_s;
      end else if (state_r == ST_SIGN) begin
        res_r <= sign_res_s;
      end else begin
        res_r <= res_r;
      end
    end
  end

  divider u_divider (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (div_start_s),
    .i_dividend  (mag1_s),
    .i_divisor   (mag2_s),
    .o_done      (div_done_s),
    .o_quotient  (quo_s),
    .o_remainder (rem_s)
  );

  assign o_busy = busy_r;
  assign o_done = done_r;
  assign o_res  = res_r;

endmodule

// File: tb/tb_div_top.sv
// Self-checking bench for div_top: directed vectors, randomized operations
// against an arithmetic reference model, busy/back-to-back and reset abort.
module tb_div_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  div_top dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_f3    (f3),
    .i_rs1   (rs1),
    .i_rs2   (rs2),
    .o_busy  (busy),
    .o_done  (done),
    .o_res   (res)
  );

  // RISC-V M-extension semantics with plain arithmetic.
  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic sgn;
    logic rem;
    sa  = a;
    sb  = b;
    sgn = (op == 3'b100) || (op == 3'b110);
    rem = (op == 3'b110) || (op == 3'b111);
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == 3'b100) || (op == 3'b110);
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one operation from a mid-cycle point; scramble inputs after acceptance.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] r, output bit busy_seen);
    f3 = op; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    f3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    lat = 1;
    busy_seen = busy;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      busy_seen |= busy;
    end
    r = res;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (res !== 32'd0) $display("FAIL reset_res got %h want 00000000", res); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [2:0]  d_f3  [10] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b110, 3'b100, 3'b111, 3'b100, 3'b110, 3'b101};
  logic [31:0] d_a   [10] = '{32'd20, 32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd2, 32'd2, 32'd3, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [10] = '{32'hFFFF_FFFA, 32'h0000_0002, 32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE,
                              32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
  int          d_lat [10] = '{34, 34, 34, 34, 34, 1, 1, 1, 1, 34};

  task automatic test_directed();
    int lat;
    logic [31:0] r;
    bit bs;
    for (int i = 0; i < 10; i++) begin
      run_op(d_f3[i], d_a[i], d_b[i], lat, r, bs);
      total_cnt++; if (r !== d_exp[i]) $display("FAIL dir_res[%0d] got %h want %h", i, r, d_exp[i]); else pass_cnt++;
      total_cnt++; if (lat != d_lat[i]) $display("FAIL dir_lat[%0d] got %0d want %0d", i, lat, d_lat[i]); else pass_cnt++;
      total_cnt++; if (bs !== (d_lat[i] == 34)) $display("FAIL dir_busy[%0d] got %0b want %0b", i, bs, d_lat[i] == 34); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (done !== 1'b0) $display("FAIL dir_pulse[%0d] got %0b want 0", i, done); else pass_cnt++;
      total_cnt++; if (res !== d_exp[i]) $display("FAIL dir_hold[%0d] got %h want %h", i, res, d_exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    bit bs;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, lat, r, bs);
      total_cnt++;
      if (r !== model_res(op, a, b))
        $display("FAIL rnd_res f3=%b a=%h b=%h got %h want %h", op, a, b, r, model_res(op, a, b));
      else pass_cnt++;
      total_cnt++;
      if (lat != model_lat(op, a, b))
        $display("FAIL rnd_lat f3=%b a=%h b=%h got %0d want %0d", op, a, b, lat, model_lat(op, a, b));
      else pass_cnt++;
    end
  endtask

  task automatic test_busy();
    int lat;
    logic [31:0] want;
    want = model_res(3'b100, 32'hFFFF_FC18, 32'd7);
    f3 = 3'b100; rs1 = 32'hFFFF_FC18; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (9) begin @(posedge clk); #1; lat++; end
    total_cnt++; if (busy !== 1'b1) $display("FAIL busy_mid got %0b want 1", busy); else pass_cnt++;
    f3 = 3'b101; rs1 = 32'd99; rs2 = 32'd0; start = 1'b1;
    @(posedge clk); #1; lat++;
    f3 = 3'b111; rs1 = 32'd1234; rs2 = 32'd10;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    total_cnt++; if (res !== want) $display("FAIL busy_res got %h want %h", res, want); else pass_cnt++;
    total_cnt++; if (lat != 34) $display("FAIL busy_lat got %0d want 34", lat); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL busy_nodup got %0b want 0", done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] r;
    bit bs;
    run_op(3'b101, 32'd1000, 32'd3, lat, r, bs);
    total_cnt++; if (r !== 32'd333) $display("FAIL b2b_first got %h want %h", r, 32'd333); else pass_cnt++;
    run_op(3'b110, 32'hFFFF_FF9C, 32'd7, lat, r, bs);
    total_cnt++; if (r !== model_res(3'b110, 32'hFFFF_FF9C, 32'd7))
      $display("FAIL b2b_second got %h want %h", r, model_res(3'b110, 32'hFFFF_FF9C, 32'd7)); else pass_cnt++;
    total_cnt++; if (lat != 34) $display("FAIL b2b_lat got %0d want 34", lat); else pass_cnt++;
    run_op(3'b111, 32'd77, 32'd0, lat, r, bs);
    total_cnt++; if (r !== 32'd77) $display("FAIL b2b_dz got %h want %h", r, 32'd77); else pass_cnt++;
    total_cnt++; if (lat != 1) $display("FAIL b2b_dz_lat got %0d want 1", lat); else pass_cnt++;
  endtask

  task automatic test_midreset();
    int lat;
    int seen;
    logic [31:0] r;
    bit bs;
    f3 = 3'b100; rs1 = 32'd500; rs2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mrst_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (res !== 32'd0) $display("FAIL mrst_res got %h want 00000000", res); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    total_cnt++; if (seen != 0) $display("FAIL mrst_nodone got %0d pulses want 0", seen); else pass_cnt++;
    run_op(3'b101, 32'd100, 32'd7, lat, r, bs);
    total_cnt++; if (r !== 32'h0000_000E) $display("FAIL mrst_after got %h want 0000000e", r); else pass_cnt++;
    total_cnt++; if (lat != 34) $display("FAIL mrst_lat got %0d want 34", lat); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy();
    test_back_to_back();
    test_midreset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
